// File: rtl/beat_sense_hub_if.sv
// Bundles the control, sample and beat-report signals of beat_sense_hub.
// The master drives enable, samples and threshold; the slave returns beat status.
interface beat_sense_hub_if #(
  parameter int NUM_AXES = 3,
  parameter int DATA_W   = 16
);
  logic                         en;
  logic                         sample_valid;
  logic [NUM_AXES*DATA_W-1:0]   sample_data;
  logic [DATA_W+3:0]            thr;
  logic                         beat;
  logic [1:0]                   beat_int;
  logic                         tick;
  logic [1:0]                   state;

  modport master (
    output en, sample_valid, sample_data, thr,
    input  beat, beat_int, tick, state
  );

  modport slave (
    input  en, sample_valid, sample_data, thr,
    output beat, beat_int, tick, state
  );
endinterface

// File: rtl/beat_sense_hub.sv
// Beat detector: compares summed absolute acceleration between periodic
// evaluation ticks and pulses beat when the change crosses a threshold.
module beat_sense_hub #(
  parameter int TICK_DIV      = 500000,
  parameter int NUM_AXES      = 3,
  parameter int DATA_W        = 16,
  parameter int REFRACT_TICKS = 20,
  parameter int STALE_TICKS   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  beat_sense_hub_if.slave  bus
);

  localparam int MAG_W = DATA_W + 4;
  localparam int CMP_W = DATA_W + 6;
  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int REF_W = $clog2(REFRACT_TICKS + 1);
  localparam int STL_W = $clog2(STALE_TICKS + 1);

  localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [REF_W-1:0] REF_LOAD   = REF_W'(REFRACT_TICKS);
  localparam logic [STL_W-1:0] STALE_LAST = STL_W'(STALE_TICKS - 1);
  localparam logic [STL_W-1:0] STALE_SAT  = STL_W'(STALE_TICKS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    REFRACT = 2'd2
  } state_t;

  state_t                       state_q, state_d;
  logic [CNT_W-1:0]             tick_cnt, tick_cnt_d;
  logic                         tick_q;
  logic                         fresh_q;
  logic [NUM_AXES*DATA_W-1:0]   hold_q;
  logic [MAG_W-1:0]             prev_mag_q, prev_mag_d;
  logic [STL_W-1:0]             stale_q, stale_d;
  logic [REF_W-1:0]             refr_q, refr_d;
  logic                         beat_q, beat_d;
  logic [1:0]                   beat_int_q, beat_int_d;

  logic [MAG_W-1:0]             mag;
  logic [MAG_W-1:0]             delta;
  logic [CMP_W-1:0]             delta_ext, thr_ext, thr_x2, thr_x4;
  logic                         eval, stale_tick, stale_hit;

  // Sign-extend each channel before negating so the most negative code keeps its full magnitude.
  always_comb begin
    logic [DATA_W-1:0] ch;
    logic [MAG_W-1:0]  ch_ext;
    mag = '0;
    for (int i = 0; i < NUM_AXES; i++) begin
      ch     = hold_q[i*DATA_W +: DATA_W];
      ch_ext = {{4{ch[DATA_W-1]}}, ch};
      mag    = mag + (ch[DATA_W-1] ? (~ch_ext + MAG_W'(1)) : ch_ext);
    end
  end

  assign delta      = (mag >= prev_mag_q) ? (mag - prev_mag_q) : (prev_mag_q - mag);
  assign delta_ext  = CMP_W'(delta);
  assign thr_ext    = CMP_W'(bus.thr);
  assign thr_x2     = thr_ext << 1;
  assign thr_x4     = thr_ext << 2;
  assign eval       = tick_q & fresh_q;
  assign stale_tick = tick_q & ~fresh_q;
  assign stale_hit  = stale_tick & (stale_q >= STALE_LAST);
  assign tick_cnt_d = (tick_cnt == TICK_LAST) ? '0 : tick_cnt + CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    beat_d     = 1'b0;
    beat_int_d = beat_int_q;
    refr_d     = refr_q;
    stale_d    = stale_q;
    prev_mag_d = prev_mag_q;

    if (eval) begin
      stale_d = '0;
      if (!(state_q == IDLE && !bus.en)) prev_mag_d = mag;
    end else if (stale_tick) begin
      stale_d = stale_hit ? STALE_SAT : stale_q + STL_W'(1);
    end

    if (state_q == REFRACT && tick_q && refr_q != '0) refr_d = refr_q - REF_W'(1);

    case (state_q)
      IDLE: if (eval) state_d = ARMED;
      ARMED: begin
        if (eval && bus.thr != '0 && delta_ext >= thr_ext) begin
          beat_d     = 1'b1;
          beat_int_d = (delta_ext >= thr_x4) ? 2'd3 : (delta_ext >= thr_x2) ? 2'd2 : 2'd1;
          refr_d     = REF_LOAD;
          state_d    = REFRACT;
        end
      end
      REFRACT: if (tick_q && refr_q <= REF_W'(1)) state_d = ARMED;
      default: state_d = IDLE;
    endcase

    // Losing the sample stream invalidates the baseline, so drop back and forget the last intensity.
    if (stale_hit) begin
      state_d    = IDLE;
      beat_d     = 1'b0;
      beat_int_d = 2'd0;
    end
    if (!bus.en) begin
      state_d = IDLE;
      beat_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // A sample arriving on a tick edge survives the clear so it is evaluated on the next tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt   <= '0;
      tick_q     <= 1'b0;
      fresh_q    <= 1'b0;
      hold_q     <= '0;
      prev_mag_q <= '0;
      stale_q    <= '0;
      refr_q     <= '0;
      beat_q     <= 1'b0;
      beat_int_q <= 2'd0;
    end else begin
      tick_cnt   <= tick_cnt_d;
      tick_q     <= (tick_cnt_d == TICK_LAST);
      fresh_q    <= bus.sample_valid | (fresh_q & ~tick_q);
      if (bus.sample_valid) hold_q <= bus.sample_data;
      prev_mag_q <= prev_mag_d;
      stale_q    <= stale_d;
      refr_q     <= refr_d;
      beat_q     <= beat_d;
      beat_int_q <= beat_int_d;
    end
  end

  assign bus.beat     = beat_q;
  assign bus.beat_int = beat_int_q;
  assign bus.tick     = tick_q;
  assign bus.state    = state_q;

endmodule
